// File: rtl/mac_pkg.sv
// Shared MAC datapath constants and the multiplier state encoding.
// The accumulator downstream uses MAC_ACC_W (product width plus one carry bit).
package mac_pkg;

  localparam int MAC_WIDTH  = 8;
  localparam int MAC_PROD_W = 2 * MAC_WIDTH;
  localparam int MAC_ACC_W  = MAC_PROD_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mac_seq_multiplier.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle, single-cycle valid pulse.
// Define MAC_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module mac_seq_multiplier
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 clear_in,
  input  logic                 start,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   mult_result,
  output logic                 clear_mode,
  output logic                 valid
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            clr_q, clr_d;
  logic [PW-1:0]   mult_result_q, mult_result_d;
  logic            clear_mode_q, clear_mode_d;
  logic            valid_q, valid_d;

  logic [PW-1:0]    acc_next;
  logic [WIDTH-1:0] mplier_shift;
  logic             last_step;

  assign acc_next     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_shift = mplier_q >> 1;

  always_comb begin
    last_step = (cnt_q == CW'(WIDTH - 1));
`ifdef MAC_MULT_EARLY_TERM_EN
    // No set bits left to consume: the accumulator already holds the product.
    last_step = last_step | (mplier_shift == '0);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)     state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q == ST_RUN);
  end

  always_comb begin
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    clr_d         = clr_q;
    mult_result_d = mult_result_q;
    clear_mode_d  = clear_mode_q;
    valid_d       = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        mcand_d  = {{WIDTH{1'b0}}, a_in};
        mplier_d = b_in;
        acc_d    = '0;
        cnt_d    = '0;
        clr_d    = clear_in;
      end
    end else begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_shift;
      cnt_d    = cnt_q + CW'(1);
      if (last_step) begin
        mult_result_d = acc_next;
        clear_mode_d  = clr_q;
        valid_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q       <= '0;
      mplier_q      <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      clr_q         <= 1'b0;
      mult_result_q <= '0;
      clear_mode_q  <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      clr_q         <= clr_d;
      mult_result_q <= mult_result_d;
      clear_mode_q  <= clear_mode_d;
      valid_q       <= valid_d;
    end
  end

  assign mult_result = mult_result_q;
  assign clear_mode  = clear_mode_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_mac_seq_multiplier.sv
// Directed bench for mac_seq_multiplier; inputs change and outputs are sampled on the falling edge.
module tb_mac_seq_multiplier;

  localparam int W = 8;
`ifdef MAC_MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a_in, b_in;
  logic           clear_in, start;
  logic           busy, clear_mode, valid;
  logic [2*W-1:0] mult_result;

  int n_checks = 0;
  int n_fail   = 0;

  mac_seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clear_in(clear_in),
    .start(start), .busy(busy), .mult_result(mult_result),
    .clear_mode(clear_mode), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Latency in cycles after acceptance for multiplier b.
  function automatic int exp_lat(input logic [W-1:0] b);
    int l;
    if (!EARLY) return W;
    l = 1;
    for (int i = 0; i < W; i++) if (b[i]) l = i + 1;
    return l;
  endfunction

  // Called at a falling edge; leaves the bench at the falling edge after acceptance.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    a_in = a; b_in = b; clear_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_in = 'x; b_in = 'x; clear_in = 1'bx;
  endtask

  // Waits for valid (bounded); reports cycles waited and busy cycles seen before it.
  task automatic wait_valid(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
      if (valid) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [15:0] exp_p);
    int lat, bcnt;
    start_op(a, b, c);
    wait_valid(lat, bcnt);
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_lat"}, lat, exp_lat(b));
    chk({tag, "_busycnt"}, bcnt, exp_lat(b));
    chk({tag, "_busy_in_valid"}, busy, 0);
    chk({tag, "_result"}, mult_result, exp_p);
    chk({tag, "_clrmode"}, clear_mode, c);
  endtask

  initial begin
    int lat, bcnt, vcount, gap;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; clear_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_result", mult_result, 0);
    chk("rst_clrmode", clear_mode, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("t1", 8'h0F, 8'h03, 1'b1, 16'h002D);
    @(negedge clk);
    chk("t1_valid_clear", valid, 0);

    run_op("t2", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    @(negedge clk);
    chk("t2_valid_clear", valid, 0);
    repeat (3) @(negedge clk);
    chk("t2_hold", mult_result, 16'hFE01);

    // Starts issued while busy must be ignored.
    start_op(8'h12, 8'h34, 1'b1);
    @(negedge clk);
    vcount = 0;
    for (int cyc = 2; cyc <= 12; cyc++) begin
      if (cyc == 3 || cyc == 5) begin
        a_in = 8'h55; b_in = 8'h02; clear_in = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (valid) begin
        vcount++;
        chk("t3_result", mult_result, 16'h03A8);
        chk("t3_clrmode", clear_mode, 1);
      end
    end
    start = 1'b0;
    chk("t3_valid_count", vcount, 1);
    chk("t3_idle", busy, 0);

    // Back-to-back: new start in the valid cycle.
    start_op(8'h10, 8'h10, 1'b0);
    wait_valid(lat, bcnt);
    chk("t4a_valid", valid, 1);
    chk("t4a_result", mult_result, 16'h0100);
    a_in = 8'h02; b_in = 8'h03; clear_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_busy_after_b2b", busy, 1);
    chk("t4_valid_selfclear", valid, 0);
    wait_valid(lat, bcnt);
    gap = lat + 1;
    chk("t4b_valid", valid, 1);
    chk("t4b_result", mult_result, 16'h0006);
    chk("t4b_clrmode", clear_mode, 1);
    chk("t4_gap", gap, exp_lat(8'h03) + 1);
    @(negedge clk);

    // Reset in the middle of an operation.
    start_op(8'hAA, 8'h55, 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", valid, 0);
    chk("t5_rst_result", mult_result, 0);
    chk("t5_rst_clrmode", clear_mode, 0);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("t5_no_valid_after_rst", vcount, 0);
    run_op("t5_new", 8'h07, 8'h07, 1'b1, 16'h0031);
    @(negedge clk);

    run_op("t6_b00", 8'h9C, 8'h00, 1'b0, 16'h0000);
    @(negedge clk);
    run_op("t6_b01", 8'h9C, 8'h01, 1'b1, 16'h009C);
    @(negedge clk);
    run_op("t6_b80", 8'h03, 8'h80, 1'b0, 16'h0180);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
